// File: rtl/nunchuk_decoder.sv
// Streaming Wii Nunchuk report decoder: assembles 6-byte frames and registers the decoded outputs.
// Defining NUNCHUK_AVG_EN block-averages the accelerometer over 2^AVG_LOG2 frames.
module nunchuk_decoder #(
    parameter int unsigned ACCEL_W  = 10,
    parameter int unsigned DEADZONE = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               frame_start,
    output logic [7:0]         stick_x,
    output logic [7:0]         stick_y,
    output logic [ACCEL_W-1:0] accel_x,
    output logic [ACCEL_W-1:0] accel_y,
    output logic [ACCEL_W-1:0] accel_z,
    output logic               z,
    output logic               c,
    output logic               z_press,
    output logic               c_press,
    output logic               z_release,
    output logic               c_release,
    output logic               frame_valid,
    output logic               accel_valid,
    output logic               frame_err
);

    if (ACCEL_W < 1 || ACCEL_W > 10) begin : g_bad_accel_w
        $error("nunchuk_decoder: ACCEL_W must be 1..10");
    end
    if (DEADZONE > 127) begin : g_bad_deadzone
        $error("nunchuk_decoder: DEADZONE must be 0..127");
    end
    if (AVG_LOG2 > 4) begin : g_bad_avg_log2
        $error("nunchuk_decoder: AVG_LOG2 must be 0..4");
    end

    logic [2:0]      idx_q, idx_d;
    logic [5:0][7:0] hold_q, hold_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;

    // Byte capture; pend_q marks a complete frame sitting in hold_q for one cycle.
    always_comb begin
        idx_d  = idx_q;
        hold_d = hold_q;
        pend_d = 1'b0;
        err_d  = 1'b0;
        if (byte_valid) begin
            if (frame_start) begin
                hold_d[0] = byte_in;
                idx_d     = 3'd1;
                err_d     = (idx_q != 3'd0);
            end else begin
                hold_d[idx_q] = byte_in;
                if (idx_q == 3'd5) begin
                    idx_d  = 3'd0;
                    pend_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 3'd0;
            hold_q <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign frame_err = err_q;

    logic [9:0] raw_ax, raw_ay, raw_az;
    logic       z_new, c_new;

    assign raw_ax = {hold_q[2], hold_q[5][3:2]};
    assign raw_ay = {hold_q[3], hold_q[5][5:4]};
    assign raw_az = {hold_q[4], hold_q[5][7:6]};
    assign z_new  = ~hold_q[5][0];
    assign c_new  = ~hold_q[5][1];

    // raw ^ 0x80 is raw - 128 as signed 8-bit; magnitude needs 9 bits for -128.
    function automatic logic [7:0] stick_decode(input logic [7:0] raw);
        logic [7:0] s;
        logic [8:0] mag;
        s   = raw ^ 8'h80;
        mag = s[7] ? (9'd256 - {1'b0, s}) : {1'b0, s};
        return (mag <= 9'(DEADZONE)) ? 8'h00 : s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stick_x     <= 8'h00;
            stick_y     <= 8'h00;
            z           <= 1'b0;
            c           <= 1'b0;
            z_press     <= 1'b0;
            c_press     <= 1'b0;
            z_release   <= 1'b0;
            c_release   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= pend_q;
            z_press     <= 1'b0;
            c_press     <= 1'b0;
            z_release   <= 1'b0;
            c_release   <= 1'b0;
            if (pend_q) begin
                stick_x   <= stick_decode(hold_q[0]);
                stick_y   <= stick_decode(hold_q[1]);
                z         <= z_new;
                c         <= c_new;
                z_press   <= z_new & ~z;
                c_press   <= c_new & ~c;
                z_release <= ~z_new & z;
                c_release <= ~c_new & c;
            end
        end
    end

`ifdef NUNCHUK_AVG_EN
    localparam int unsigned AccW = 10 + AVG_LOG2;
    localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [AccW-1:0] acc_x_q, acc_y_q, acc_z_q;
    logic [AccW-1:0] sum_x, sum_y, sum_z;
    logic [9:0]      avg_x, avg_y, avg_z;
    logic [CntW-1:0] cnt_q;
    logic            last_frame;

    // The current frame is folded into the sum so the block result is ready on its last frame.
    always_comb begin
        sum_x      = acc_x_q + AccW'(raw_ax);
        sum_y      = acc_y_q + AccW'(raw_ay);
        sum_z      = acc_z_q + AccW'(raw_az);
        avg_x      = 10'(sum_x >> AVG_LOG2);
        avg_y      = 10'(sum_y >> AVG_LOG2);
        avg_z      = 10'(sum_z >> AVG_LOG2);
        last_frame = (cnt_q == CntW'((1 << AVG_LOG2) - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            acc_z_q     <= '0;
            cnt_q       <= '0;
            accel_x     <= '0;
            accel_y     <= '0;
            accel_z     <= '0;
            accel_valid <= 1'b0;
        end else begin
            accel_valid <= 1'b0;
            if (pend_q) begin
                if (last_frame) begin
                    accel_x     <= avg_x[9 -: ACCEL_W];
                    accel_y     <= avg_y[9 -: ACCEL_W];
                    accel_z     <= avg_z[9 -: ACCEL_W];
                    accel_valid <= 1'b1;
                    acc_x_q     <= '0;
                    acc_y_q     <= '0;
                    acc_z_q     <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_x_q <= sum_x;
                    acc_y_q <= sum_y;
                    acc_z_q <= sum_z;
                    cnt_q   <= cnt_q + CntW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accel_x     <= '0;
            accel_y     <= '0;
            accel_z     <= '0;
            accel_valid <= 1'b0;
        end else begin
            accel_valid <= pend_q;
            if (pend_q) begin
                accel_x <= raw_ax[9 -: ACCEL_W];
                accel_y <= raw_ay[9 -: ACCEL_W];
                accel_z <= raw_az[9 -: ACCEL_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_nunchuk_decoder.sv
// Directed self-checking bench for nunchuk_decoder; three instances share one byte stream.
module tb_nunchuk_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       frame_start;

    always #5 clk = ~clk;

    // Main instance: ACCEL_W=10, DEADZONE=8, AVG_LOG2=0
    logic [7:0] m_sx, m_sy;
    logic [9:0] m_ax, m_ay, m_az;
    logic       m_z, m_c, m_zp, m_cp, m_zr, m_cr, m_fv, m_av, m_fe;
    // Narrow instance: ACCEL_W=8, AVG_LOG2=2
    logic [7:0] w_sx, w_sy;
    logic [7:0] w_ax, w_ay, w_az;
    logic       w_z, w_c, w_zp, w_cp, w_zr, w_cr, w_fv, w_av, w_fe;
    // Averaging instance: ACCEL_W=10, AVG_LOG2=2
    logic [7:0] a_sx, a_sy;
    logic [9:0] a_ax, a_ay, a_az;
    logic       a_z, a_c, a_zp, a_cp, a_zr, a_cr, a_fv, a_av, a_fe;

    nunchuk_decoder #(.ACCEL_W(10), .DEADZONE(8), .AVG_LOG2(0)) u_main (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_start(frame_start), .stick_x(m_sx), .stick_y(m_sy),
        .accel_x(m_ax), .accel_y(m_ay), .accel_z(m_az), .z(m_z), .c(m_c),
        .z_press(m_zp), .c_press(m_cp), .z_release(m_zr), .c_release(m_cr),
        .frame_valid(m_fv), .accel_valid(m_av), .frame_err(m_fe)
    );

    nunchuk_decoder #(.ACCEL_W(8), .DEADZONE(8), .AVG_LOG2(2)) u_w8 (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_start(frame_start), .stick_x(w_sx), .stick_y(w_sy),
        .accel_x(w_ax), .accel_y(w_ay), .accel_z(w_az), .z(w_z), .c(w_c),
        .z_press(w_zp), .c_press(w_cp), .z_release(w_zr), .c_release(w_cr),
        .frame_valid(w_fv), .accel_valid(w_av), .frame_err(w_fe)
    );

    nunchuk_decoder #(.ACCEL_W(10), .DEADZONE(8), .AVG_LOG2(2)) u_avg (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_start(frame_start), .stick_x(a_sx), .stick_y(a_sy),
        .accel_x(a_ax), .accel_y(a_ay), .accel_z(a_az), .z(a_z), .c(a_c),
        .z_press(a_zp), .c_press(a_cp), .z_release(a_zr), .c_release(a_cr),
        .frame_valid(a_fv), .accel_valid(a_av), .frame_err(a_fe)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int fv_cnt       = 0;
    int err_cnt      = 0;

    always @(negedge clk) begin
        if (m_fv) fv_cnt++;
        if (m_fe) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic s);
        byte_in     = b;
        byte_valid  = 1'b1;
        frame_start = s;
        @(posedge clk);
        #1;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], i == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        idle(2);
        tests_run++;
        if ({m_sx, m_sy, m_ax, m_ay, m_az} !== 46'h0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h, want 0", {m_sx, m_sy, m_ax, m_ay, m_az});
        end
        tests_run++;
        if ({m_z, m_c, m_zp, m_cp, m_zr, m_cr, m_fv, m_av, m_fe} !== 9'h0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, want 0",
                     {m_z, m_c, m_zp, m_cp, m_zr, m_cr, m_fv, m_av, m_fe});
        end
        tests_run++;
        if ({w_ax, a_ax} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_aux_accel: got %h, want 0", {w_ax, a_ax});
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        send_frame(48'h80_7F_12_34_56_E6);
        tests_run++;
        if (m_fv !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_latency: frame_valid got %b, want 0", m_fv);
        end
        idle(1);
        tests_run++;
        if ({m_sx, m_sy} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL basic_stick: got %h, want 0000", {m_sx, m_sy});
        end
        tests_run++;
        if ({m_ax, m_ay, m_az} !== {10'h049, 10'h0D2, 10'h15B}) begin
            tests_failed++;
            $display("FAIL basic_accel: got %h %h %h, want 049 0d2 15b", m_ax, m_ay, m_az);
        end
        tests_run++;
        if ({m_z, m_c, m_zp, m_zr, m_cp, m_cr, m_fv, m_av} !== 8'b1010_0011) begin
            tests_failed++;
            $display("FAIL basic_buttons: got %b, want 10100011",
                     {m_z, m_c, m_zp, m_zr, m_cp, m_cr, m_fv, m_av});
        end
        idle(1);
        tests_run++;
        if ({m_fv, m_av, m_zp, m_z} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL basic_pulse_end: got %b, want 0001", {m_fv, m_av, m_zp, m_z});
        end
    endtask

    task automatic test_stick();
        logic [7:0] raw [6];
        logic [7:0] exp [6];
        raw = '{8'hFF, 8'h00, 8'h88, 8'h89, 8'h78, 8'h77};
        exp = '{8'h7F, 8'h80, 8'h00, 8'h09, 8'h00, 8'hF7};
        for (int i = 0; i < 6; i++) begin
            send_frame({raw[i], 40'h7F_12_34_56_E6});
            idle(1);
            tests_run++;
            if ({m_fv, m_sx, m_sy} !== {1'b1, exp[i], 8'h00}) begin
                tests_failed++;
                $display("FAIL stick_%0d: raw %h got fv=%b x=%h y=%h, want fv=1 x=%h y=00",
                         i, raw[i], m_fv, m_sx, m_sy, exp[i]);
            end
        end
    endtask

    task automatic test_buttons();
        logic [7:0] b5 [5];
        logic [5:0] exp [5];
        // exp = {z, c, z_press, z_release, c_press, c_release}; prior state z=1, c=0
        b5  = '{8'hE7, 8'hE6, 8'hE7, 8'hE5, 8'hE6};
        exp = '{6'b00_0100, 6'b10_1000, 6'b00_0100, 6'b01_0010, 6'b10_1001};
        for (int i = 0; i < 5; i++) begin
            send_frame({40'h80_80_12_34_56, b5[i]});
            idle(1);
            tests_run++;
            if ({m_z, m_c, m_zp, m_zr, m_cp, m_cr} !== exp[i]) begin
                tests_failed++;
                $display("FAIL buttons_%0d: b5 %h got %b, want %b", i, b5[i],
                         {m_z, m_c, m_zp, m_zr, m_cp, m_cr}, exp[i]);
            end
        end
    endtask

    task automatic test_frame_err();
        int e0, f0;
        idle(2);
        e0 = err_cnt;
        f0 = fv_cnt;
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        tests_run++;
        if (m_fe !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_err_pulse: frame_err got %b, want 1", m_fe);
        end
        send_byte(8'h80, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'hE6, 1'b0);
        idle(1);
        tests_run++;
        if ({m_fv, m_sx, m_sy} !== {1'b1, 8'h80, 8'h00}) begin
            tests_failed++;
            $display("FAIL abort_restart_decode: got fv=%b x=%h y=%h, want fv=1 x=80 y=00",
                     m_fv, m_sx, m_sy);
        end
        idle(2);
        tests_run++;
        if ({err_cnt - e0, fv_cnt - f0} !== {32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL abort_counts: err=%0d fv=%0d, want err=1 fv=1",
                     err_cnt - e0, fv_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        e0 = err_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tests_run++;
        if ({m_sx, m_fe} !== 9'h0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got x=%h err=%b, want 00 0", m_sx, m_fe);
        end
        send_frame(48'h89_80_12_34_56_E6);
        idle(1);
        tests_run++;
        if ({m_fv, m_sx, m_zp} !== {1'b1, 8'h09, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_frame: got fv=%b x=%h zp=%b, want 1 09 1", m_fv, m_sx, m_zp);
        end
        idle(1);
        tests_run++;
        if (err_cnt != e0) begin
            tests_failed++;
            $display("FAIL midreset_no_err: frame_err pulses %0d, want 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] fr [3];
        logic [7:0]  exp [3];
        int          f0;
        fr  = '{48'hFF_80_12_34_56_E6, 48'h00_80_12_34_56_E6, 48'h89_80_12_34_56_E6};
        exp = '{8'h7F, 8'h80, 8'h09};
        f0  = fv_cnt;
        // Later frames carry no frame_start: free-running framing.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 6; i++) begin
                send_byte(fr[f][47-8*i -: 8], (f == 0) && (i == 0));
                if (f > 0 && i == 0) begin
                    tests_run++;
                    if ({m_fv, m_sx} !== {1'b1, exp[f-1]}) begin
                        tests_failed++;
                        $display("FAIL b2b_frame_%0d: got fv=%b x=%h, want fv=1 x=%h",
                                 f - 1, m_fv, m_sx, exp[f-1]);
                    end
                end
            end
        end
        idle(1);
        tests_run++;
        if ({m_fv, m_sx} !== {1'b1, exp[2]}) begin
            tests_failed++;
            $display("FAIL b2b_frame_2: got fv=%b x=%h, want fv=1 x=%h", m_fv, m_sx, exp[2]);
        end
        idle(2);
        tests_run++;
        if (fv_cnt - f0 != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: frame_valid pulses %0d, want 3", fv_cnt - f0);
        end
    endtask

    task automatic test_accel_w8();
        do_reset();
        for (int k = 0; k < 4; k++) send_frame(48'h80_80_FF_34_56_EE);
        idle(1);
        tests_run++;
        if ({m_ax, m_ay} !== {10'h3FF, 10'h0D2}) begin
            tests_failed++;
            $display("FAIL w10_accel: got %h %h, want 3ff 0d2", m_ax, m_ay);
        end
        tests_run++;
        if ({w_av, w_ax, w_ay} !== {1'b1, 8'hFF, 8'h34}) begin
            tests_failed++;
            $display("FAIL w8_accel: got av=%b x=%h y=%h, want av=1 x=ff y=34", w_av, w_ax, w_ay);
        end
    endtask

    task automatic test_avg();
        logic [7:0] b2 [4];
        logic [7:0] b5 [4];
        logic [9:0] raw [4];
        logic [9:0] exp_x [4];
        logic       exp_av [4];
        b2  = '{8'h40, 8'h40, 8'h41, 8'h41};
        b5  = '{8'hE2, 8'hEA, 8'hE2, 8'hEA};
        raw = '{10'h100, 10'h102, 10'h104, 10'h106};
`ifdef NUNCHUK_AVG_EN
        exp_x  = '{10'h000, 10'h000, 10'h000, 10'h103};
        exp_av = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_x  = '{10'h100, 10'h102, 10'h104, 10'h106};
        exp_av = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_frame({16'h80_80, b2[k], 16'h34_56, b5[k]});
            idle(1);
            tests_run++;
            if ({a_fv, a_av, a_ax} !== {1'b1, exp_av[k], exp_x[k]}) begin
                tests_failed++;
                $display("FAIL avg_frame_%0d: got fv=%b av=%b x=%h, want fv=1 av=%b x=%h",
                         k, a_fv, a_av, a_ax, exp_av[k], exp_x[k]);
            end
            tests_run++;
            if ({m_av, m_ax} !== {1'b1, raw[k]}) begin
                tests_failed++;
                $display("FAIL avg0_frame_%0d: got av=%b x=%h, want av=1 x=%h",
                         k, m_av, m_ax, raw[k]);
            end
        end
        tests_run++;
        if ({a_ay, a_az} !== {10'h0D2, 10'h15B}) begin
            tests_failed++;
            $display("FAIL avg_yz: got %h %h, want 0d2 15b", a_ay, a_az);
        end
        idle(1);
        tests_run++;
        if ({a_fv, a_av} !== 2'b00) begin
            tests_failed++;
            $display("FAIL avg_pulse_end: got fv=%b av=%b, want 0 0", a_fv, a_av);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stick();
        test_buttons();
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
        test_accel_w8();
        test_avg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nunchuk_decoder.md
# nunchuk_decoder

Streaming, clocked decoder for Wii Nunchuk report data, and the parametrised successor of the purely combinational translator. It consumes the 6-byte report one byte at a time from the I2C read engine and assembles complete frames. Each complete frame is decoded into registered outputs:
- centred, dead-zoned stick values;
- width-configurable accelerometer values;
- active-high button levels with press/release pulses.

It sits between the I2C master and the game/control logic. It optionally block-averages the accelerometer.

## Interface
Parameters:
- ACCEL_W, 10, output accelerometer width; legal 1..10; output is the top ACCEL_W bits of the 10-bit raw value.
- DEADZONE, 8, stick dead-zone half-width in LSBs; legal 0..127.
- AVG_LOG2, 2, log2 of accelerometer averaging block length; legal 0..4. Used only when NUNCHUK_AVG_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  report byte from the I2C engine.
- byte_valid  in  1  byte_in is valid this cycle.
- frame_start  in  1  qualifies byte_valid; marks byte_in as report byte 0.
- stick_x, stick_y  out  8  signed two's-complement stick position, centred on raw 128.
- accel_x, accel_y, accel_z  out  ACCEL_W  accelerometer value, unsigned.
- z, c  out  1  button levels, active high (pressed = 1).
- z_press, c_press  out  1  one-cycle pulse on a 0→1 button transition.
- z_release, c_release  out  1  one-cycle pulse on a 1→0 button transition.
- frame_valid  out  1  one-cycle pulse when stick/button outputs update.
- accel_valid  out  1  one-cycle pulse when accel outputs update.
- frame_err  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
- Byte index counter `idx` runs 0..5. Accepted bytes (byte_valid=1) are written to a 6-byte holding register at position `idx`.
- byte_valid with frame_start:
  - Forces `idx`=0, and the byte is stored as byte 0.
  - If `idx`≠0 at that moment, frame_err pulses. The partial frame is discarded.
- byte_valid without frame_start while `idx`=0 is accepted as byte 0 (free-running framing).
- After byte 5 is accepted, `idx` wraps to 0 and the frame is decoded. byte_valid=0 never changes `idx`.
- Raw field mapping (b0..b5 = frame bytes):
  - stick raw: b0 (x), b1 (y).
  - accel x = {b2, b5[3:2]}; accel y = {b3, b5[5:4]}; accel z = {b4, b5[7:6]}.
  - z = ~b5[0]; c = ~b5[1].
- Stick decode:
  - s = raw − 128, which fits signed 8 bits (raw 0 → −128, raw 255 → +127).
  - If |s| ≤ DEADZONE, the output is 0. Otherwise the output is s unmodified (no rescaling).
- Accel decode: out = raw10[9 -: ACCEL_W], i.e. truncation with no rounding.
- Buttons:
  - The previous-frame level is held internally (reset 0).
  - Press/release pulses compare the new level against the previous level and assert with frame_valid.
- Reset values: all outputs 0, `idx`=0, holding register 0, accumulators 0.
- Asserting rst_n low mid-frame discards the partial frame and raises no frame_err.

## Timing
- Byte 5 accepted at edge t → stick, buttons and frame_valid (plus any press/release pulses) are valid after edge t+1. Latency is 1 cycle.
- Back-to-back frames (byte_valid every cycle) are supported at full rate: one frame every 6 cycles.
- frame_err asserts the cycle after the aborting byte is accepted.
- Outputs hold their values between updates.

## Configuration
- Macro: NUNCHUK_AVG_EN.
- With NUNCHUK_AVG_EN defined:
  - Each axis has a (10+AVG_LOG2)-bit accumulator and there is a frame counter.
  - Every 2^AVG_LOG2 frames, each axis output is updated to (sum >> AVG_LOG2) truncated to ACCEL_W bits. accel_valid pulses with that frame's frame_valid.
  - The accumulators then restart from the next frame.
  - AVG_LOG2=0 behaves identically to the undefined case.
- Without NUNCHUK_AVG_EN: no accumulators are present, accel outputs update on every frame, and accel_valid equals frame_valid.

## Test plan
- Reset then frame 80 7F 12 34 56 E6 (DEADZONE=8, ACCEL_W=10) → one cycle after the last byte:
  - stick_x=0, stick_y=0;
  - accel_x=0x049, accel_y=0x0D2, accel_z=0x15B;
  - z=1, c=0, z_press=1;
  - frame_valid a single pulse.
- Stick b0 = FF, 00, 88, 89 in successive frames → stick_x = 0x7F, 0x80 (−128), 0x00, 0x09.
- Frame_start on a byte after 3 accepted bytes, then 5 more bytes → frame_err pulses once, and one frame_valid decodes the restarted frame.
- Same frame with b5=E6 then b5=E7 → frame 1 gives z_press=1; frame 2 gives z=0, z_release=1, and no press pulse.
- ACCEL_W=8, accel x raw 0x3FF → accel_x=0xFF.
- NUNCHUK_AVG_EN, AVG_LOG2=2, accel x raw 0x100, 0x102, 0x104, 0x106 → accel_valid only on the 4th frame, with accel_x=0x103; frame_valid on all 4 frames.
